main_mem_ctrl: RTL and testbench

Main-memory controller that services the core's two block-level memory ports: the icache read-only request port and the dcache read/write request port. It arbitrates round-robin between them, holds one request in flight at a time, and models a fixed-latency backing store of cache blocks. It answers with a single-cycle response pulse. It sits in the top level beside `core`, on the responder end of the icache and dcache mem-ctrl request/response interfaces.

---
 rtl/main_mem_ctrl_pkg.sv | 33 +++
 rtl/mem_ctrl_rr_arbiter.sv | 33 +++
 rtl/main_mem_ctrl.sv | 128 ++++++++++++
 tb/tb_main_mem_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_ctrl_pkg.sv
// Shared global definitions for the main-memory controller: block address/data
// types, request type, arbitration port identifiers and FSM state encodings.
package main_mem_ctrl_pkg;

  localparam int unsigned BLOCK_ADDR_BITS = 26;
  localparam int unsigned BLOCK_DATA_BITS = 128;

  typedef logic [BLOCK_ADDR_BITS-1:0] main_mem_block_addr_t;
  typedef logic [BLOCK_DATA_BITS-1:0] block_data_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } mem_port_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Round-robin pick: on a tie the port that did not win last time is chosen.
  function automatic mem_port_t rr_pick(input logic vi, input logic vd,
                                        input mem_port_t last);
    if (vi && vd) return (last == DCACHE) ? ICACHE : DCACHE;
    else if (vd)  return DCACHE;
    else          return ICACHE;
  endfunction

endpackage

// File: rtl/mem_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter between the icache and dcache request ports.
// Grant is combinational; the last winner is registered on accept.
module mem_ctrl_rr_arbiter
  import main_mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_aH,
  input  logic       i_valid_icache,
  input  logic       i_valid_dcache,
  input  logic       i_enable,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output mem_port_t  o_last_grant
);

  mem_port_t r_last_grant;
  mem_port_t w_winner;

  always_comb begin
    o_grant  = '0;
    w_winner = rr_pick(i_valid_icache, i_valid_dcache, r_last_grant);
    if (i_enable && (i_valid_icache || i_valid_dcache))
      o_grant = (w_winner == DCACHE) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH)        r_last_grant <= DCACHE;
    else if (i_accept) r_last_grant <= w_winner;
  end

  assign o_last_grant = r_last_grant;

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory controller: round-robin services icache/dcache block requests one
// at a time against a fixed-latency backing store, replying with a 1-cycle pulse.
module main_mem_ctrl
  import main_mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 10,
  parameter int unsigned N_BLOCKS    = 1024
) (
  input  logic                 clk,
  input  logic                 rst_aH,
  input  logic                 init,
  input  logic                 init_wr_valid,
  input  main_mem_block_addr_t init_wr_block_addr,
  input  block_data_t          init_wr_block_data,
  input  logic                 icache_req_valid,
  input  main_mem_block_addr_t icache_req_block_addr,
  output logic                 icache_req_ready,
  output logic                 icache_resp_valid,
  output block_data_t          icache_resp_block_data,
  input  logic                 dcache_req_valid,
  input  req_type_t            dcache_req_type,
  input  main_mem_block_addr_t dcache_req_block_addr,
  input  block_data_t          dcache_req_block_data,
  output logic                 dcache_req_ready,
  output logic                 dcache_resp_valid,
  output block_data_t          dcache_resp_block_data
);

  localparam int unsigned IDX_W = $clog2(N_BLOCKS);
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  mem_port_t        r_owner;
  block_data_t      r_data;
  block_data_t      r_mem [N_BLOCKS];

  logic [1:0]       w_grant;
  mem_port_t        w_last_grant;
  logic             w_enable;
  logic             w_accept;
  logic             w_sel_dcache;
  logic             w_acc_write;
  logic [IDX_W-1:0] w_acc_idx;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_mem_widx;
  block_data_t      w_mem_wdata;
  logic             w_unused;

  assign w_enable     = (r_state == ST_IDLE) && !init && !rst_aH;
  assign w_accept     = |w_grant;
  assign w_sel_dcache = w_grant[1];
  assign w_acc_write  = w_sel_dcache && (dcache_req_type == WRITE);
  assign w_acc_idx    = w_sel_dcache ? dcache_req_block_addr[IDX_W-1:0]
                                     : icache_req_block_addr[IDX_W-1:0];

  assign icache_req_ready = w_grant[0];
  assign dcache_req_ready = w_grant[1];

  mem_ctrl_rr_arbiter u_arb (
    .clk            (clk),
    .rst_aH         (rst_aH),
    .i_valid_icache (icache_req_valid),
    .i_valid_dcache (dcache_req_valid),
    .i_enable       (w_enable),
    .i_accept       (w_accept),
    .o_grant        (w_grant),
    .o_last_grant   (w_last_grant)
  );

  // Preload and accepted dcache writes share one store write port; they never
  // coincide because acceptance is blocked while init is high.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_widx  = init_wr_block_addr[IDX_W-1:0];
    w_mem_wdata = init_wr_block_data;
    if (init && init_wr_valid) begin
      w_mem_we = 1'b1;
    end else if (w_accept && w_acc_write) begin
      w_mem_we    = 1'b1;
      w_mem_widx  = w_acc_idx;
      w_mem_wdata = dcache_req_block_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_widx] <= w_mem_wdata;
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_owner <= ICACHE;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner <= w_sel_dcache ? DCACHE : ICACHE;
            r_data  <= w_acc_write ? dcache_req_block_data : r_mem[w_acc_idx];
            r_cnt   <= CNT_LOAD;
            r_state <= (MEM_LATENCY == 1) ? ST_RESP : ST_BUSY;
          end
        end
        // Leave BUSY as the counter steps to 0 so RESP lands exactly MEM_LATENCY after acceptance.
        ST_BUSY: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign icache_resp_valid      = (r_state == ST_RESP) && (r_owner == ICACHE);
  assign dcache_resp_valid      = (r_state == ST_RESP) && (r_owner == DCACHE);
  assign icache_resp_block_data = icache_resp_valid ? r_data : '0;
  assign dcache_resp_block_data = dcache_resp_valid ? r_data : '0;

  // Upper address bits are intentionally ignored so addresses wrap.
  assign w_unused = ^{icache_req_block_addr >> IDX_W, dcache_req_block_addr >> IDX_W,
                      init_wr_block_addr >> IDX_W, w_last_grant};

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: a vector table of single transactions plus
// sequences for arbitration, reset, init interaction and the latency-1 case.
module tb_main_mem_ctrl;
  import main_mem_ctrl_pkg::*;

  localparam int unsigned LAT = 10;
  localparam block_data_t PAT_A5 = {16{8'hA5}};
  localparam block_data_t PAT_DB = {4{32'hDEADBEEF}};
  localparam block_data_t PAT_FF = {16{8'hFF}};

  typedef struct {
    logic                 is_dc;
    logic                 wr;
    main_mem_block_addr_t addr;
    block_data_t          wdata;
    block_data_t          exp;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_aH;
  logic                 init, init_wr_valid;
  main_mem_block_addr_t init_wr_block_addr;
  block_data_t          init_wr_block_data;
  logic                 icache_req_valid;
  main_mem_block_addr_t icache_req_block_addr;
  logic                 dcache_req_valid;
  req_type_t            dcache_req_type;
  main_mem_block_addr_t dcache_req_block_addr;
  block_data_t          dcache_req_block_data;

  logic        icache_req_ready, icache_resp_valid, dcache_req_ready, dcache_resp_valid;
  block_data_t icache_resp_block_data, dcache_resp_block_data;
  logic        icache_req_ready_1, icache_resp_valid_1, dcache_req_ready_1, dcache_resp_valid_1;
  block_data_t icache_resp_block_data_1, dcache_resp_block_data_1;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  main_mem_ctrl #(.MEM_LATENCY(LAT), .N_BLOCKS(1024)) dut (
    .clk(clk), .rst_aH(rst_aH), .init(init), .init_wr_valid(init_wr_valid),
    .init_wr_block_addr(init_wr_block_addr), .init_wr_block_data(init_wr_block_data),
    .icache_req_valid(icache_req_valid), .icache_req_block_addr(icache_req_block_addr),
    .icache_req_ready(icache_req_ready), .icache_resp_valid(icache_resp_valid),
    .icache_resp_block_data(icache_resp_block_data),
    .dcache_req_valid(dcache_req_valid), .dcache_req_type(dcache_req_type),
    .dcache_req_block_addr(dcache_req_block_addr), .dcache_req_block_data(dcache_req_block_data),
    .dcache_req_ready(dcache_req_ready), .dcache_resp_valid(dcache_resp_valid),
    .dcache_resp_block_data(dcache_resp_block_data)
  );

  main_mem_ctrl #(.MEM_LATENCY(1), .N_BLOCKS(1024)) dut1 (
    .clk(clk), .rst_aH(rst_aH), .init(init), .init_wr_valid(init_wr_valid),
    .init_wr_block_addr(init_wr_block_addr), .init_wr_block_data(init_wr_block_data),
    .icache_req_valid(icache_req_valid), .icache_req_block_addr(icache_req_block_addr),
    .icache_req_ready(icache_req_ready_1), .icache_resp_valid(icache_resp_valid_1),
    .icache_resp_block_data(icache_resp_block_data_1),
    .dcache_req_valid(dcache_req_valid), .dcache_req_type(dcache_req_type),
    .dcache_req_block_addr(dcache_req_block_addr), .dcache_req_block_data(dcache_req_block_data),
    .dcache_req_ready(dcache_req_ready_1), .dcache_resp_valid(dcache_resp_valid_1),
    .dcache_resp_block_data(dcache_resp_block_data_1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issues one request on the chosen port, waits (bounded) for acceptance and response.
  task automatic do_req(input logic is_dc, input logic wr, input main_mem_block_addr_t addr,
                        input block_data_t wdata, output logic ok, output block_data_t rdata,
                        output int lat, output logic other_seen, output logic stuck);
    int   t;
    logic acc;
    acc = 1'b0; ok = 1'b0; rdata = '0; lat = -1; other_seen = 1'b0; stuck = 1'b0; t = 0;
    if (is_dc) begin
      dcache_req_valid = 1'b1;
      dcache_req_type = wr ? WRITE : READ;
      dcache_req_block_addr = addr;
      dcache_req_block_data = wdata;
    end else begin
      icache_req_valid = 1'b1;
      icache_req_block_addr = addr;
    end
    #1;
    for (int i = 0; i < 40 && !acc; i++) begin
      if (is_dc ? dcache_req_ready : icache_req_ready) begin
        acc = 1'b1;
        t = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
    for (int i = 0; i < 40 && acc && !ok; i++) begin
      if (is_dc ? icache_resp_valid : dcache_resp_valid) other_seen = 1'b1;
      if (is_dc ? dcache_resp_valid : icache_resp_valid) begin
        ok = 1'b1;
        lat = cyc - t;
        rdata = is_dc ? dcache_resp_block_data : icache_resp_block_data;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
      stuck = is_dc ? dcache_resp_valid : icache_resp_valid;
      if (is_dc ? icache_resp_valid : dcache_resp_valid) other_seen = 1'b1;
    end
  endtask

  vec_t        vecs [10];
  logic        ok, other_seen, stuck, acc, both;
  block_data_t rdata;
  int          lat, t, tn, ng, npulse, dpulse, nd;
  int          gcyc [8];
  logic        gport [8];
  main_mem_block_addr_t pre_addr [4];
  block_data_t          pre_data [4];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 26'd5,    128'h0,      PAT_A5};
    vecs[1] = '{1'b1, 1'b0, 26'd9,    128'h0,      PAT_DB};
    vecs[2] = '{1'b1, 1'b1, 26'd7,    128'h1234,   128'h1234};
    vecs[3] = '{1'b1, 1'b0, 26'd7,    128'h0,      128'h1234};
    vecs[4] = '{1'b0, 1'b0, 26'd7,    128'h0,      128'h1234};
    vecs[5] = '{1'b1, 1'b1, 26'd1027, 128'hCAFE,   128'hCAFE};
    vecs[6] = '{1'b0, 1'b0, 26'd3,    128'h0,      128'hCAFE};
    vecs[7] = '{1'b1, 1'b0, 26'd1023, 128'h0,      PAT_FF};
    vecs[8] = '{1'b0, 1'b0, 26'd2047, 128'h0,      PAT_FF};
    vecs[9] = '{1'b0, 1'b0, 26'd0,    128'h0,      128'h1};
    pre_addr[0] = 26'd5;    pre_data[0] = PAT_A5;
    pre_addr[1] = 26'd9;    pre_data[1] = PAT_DB;
    pre_addr[2] = 26'd0;    pre_data[2] = 128'h1;
    pre_addr[3] = 26'd1023; pre_data[3] = PAT_FF;

    rst_aH = 1'b1; init = 1'b0; init_wr_valid = 1'b0;
    init_wr_block_addr = '0; init_wr_block_data = '0;
    icache_req_valid = 1'b1; icache_req_block_addr = 26'd5;
    dcache_req_valid = 1'b1; dcache_req_type = READ;
    dcache_req_block_addr = 26'd9; dcache_req_block_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset icache_ready", 128'(icache_req_ready), 128'(0));
    chk("reset dcache_ready", 128'(dcache_req_ready), 128'(0));
    chk("reset icache_resp_valid", 128'(icache_resp_valid), 128'(0));
    chk("reset dcache_resp_valid", 128'(dcache_resp_valid), 128'(0));
    chk("reset icache_resp_data", icache_resp_block_data, 128'h0);
    chk("reset dcache_resp_data", dcache_resp_block_data, 128'h0);
    icache_req_valid = 1'b0; dcache_req_valid = 1'b0;
    rst_aH = 1'b0;
    @(posedge clk); #1;

    // Preload with a requester waiting: readiness must stay low under init.
    init = 1'b1;
    icache_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      init_wr_valid = 1'b1;
      init_wr_block_addr = pre_addr[i];
      init_wr_block_data = pre_data[i];
      #1;
      if (i == 0) chk("init blocks icache_ready", 128'(icache_req_ready), 128'(0));
      @(posedge clk); #1;
    end
    init_wr_valid = 1'b0; init = 1'b0; icache_req_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].is_dc, vecs[i].wr, vecs[i].addr, vecs[i].wdata, ok, rdata, lat, other_seen, stuck);
      chk($sformatf("vec%0d completed", i), 128'(ok), 128'(1));
      chk($sformatf("vec%0d data", i), rdata, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), 128'(lat), 128'(LAT));
      chk($sformatf("vec%0d other port silent", i), 128'(other_seen), 128'(0));
      chk($sformatf("vec%0d single-cycle pulse", i), 128'(stuck), 128'(0));
    end

    // Both ports valid continuously from reset: I, D, I, D every LAT+1 cycles.
    rst_aH = 1'b1;
    icache_req_valid = 1'b1; icache_req_block_addr = 26'd5;
    dcache_req_valid = 1'b1; dcache_req_type = READ; dcache_req_block_addr = 26'd9;
    @(posedge clk); #1;
    rst_aH = 1'b0;
    #1;
    ng = 0; both = 1'b0; t = cyc;
    for (int k = 0; k < 8; k++) begin gcyc[k] = -1; gport[k] = 1'b0; end
    for (int i = 0; i < 40; i++) begin
      if (icache_req_ready && dcache_req_ready) both = 1'b1;
      if (icache_req_ready && ng < 8) begin gcyc[ng] = cyc - t; gport[ng] = 1'b0; ng++; end
      else if (dcache_req_ready && ng < 8) begin gcyc[ng] = cyc - t; gport[ng] = 1'b1; ng++; end
      @(posedge clk); #1;
    end
    icache_req_valid = 1'b0; dcache_req_valid = 1'b0;
    chk("rr grant count", 128'(ng), 128'(4));
    chk("rr never both ready", 128'(both), 128'(0));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr grant%0d port", k), 128'(gport[k]), 128'(k % 2));
      chk($sformatf("rr grant%0d cycle", k), 128'(gcyc[k]), 128'(k * (LAT + 1)));
    end
    repeat (15) @(posedge clk);
    #1;

    // Reset four cycles into an icache read drops it; next request accepted at once.
    icache_req_valid = 1'b1; icache_req_block_addr = 26'd5;
    #1;
    acc = 1'b0; t = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (icache_req_ready) begin acc = 1'b1; t = cyc; end
      else begin @(posedge clk); #1; end
    end
    chk("rst-mid accepted", 128'(acc), 128'(1));
    @(posedge clk); #1;
    icache_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_aH = 1'b1;
    icache_req_valid = 1'b1; icache_req_block_addr = 26'd9;
    dcache_req_valid = 1'b1; dcache_req_type = READ; dcache_req_block_addr = 26'd7;
    #1;
    chk("rst-mid icache_ready in reset", 128'(icache_req_ready), 128'(0));
    chk("rst-mid dcache_ready in reset", 128'(dcache_req_ready), 128'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_aH = 1'b0;
    #1;
    chk("post-rst icache_ready", 128'(icache_req_ready), 128'(1));
    chk("post-rst dcache_ready", 128'(dcache_req_ready), 128'(0));
    tn = cyc;
    @(posedge clk); #1;
    icache_req_valid = 1'b0; dcache_req_valid = 1'b0;
    npulse = 0; dpulse = 0; lat = -1; rdata = '0;
    for (int i = 0; i < 20; i++) begin
      if (icache_resp_valid) begin npulse++; lat = cyc - tn; rdata = icache_resp_block_data; end
      if (dcache_resp_valid) dpulse++;
      @(posedge clk); #1;
    end
    chk("post-rst icache pulses", 128'(npulse), 128'(1));
    chk("post-rst latency", 128'(lat), 128'(LAT));
    chk("post-rst data", rdata, PAT_DB);
    chk("post-rst dcache pulses", 128'(dpulse), 128'(0));

    // init raised mid-transaction: in-flight read completes, new acceptance blocked.
    icache_req_valid = 1'b1; icache_req_block_addr = 26'd5;
    #1;
    acc = 1'b0; t = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (icache_req_ready) begin acc = 1'b1; t = cyc; end
      else begin @(posedge clk); #1; end
    end
    chk("init-mid accepted", 128'(acc), 128'(1));
    @(posedge clk); #1;
    icache_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    init = 1'b1;
    dcache_req_valid = 1'b1; dcache_req_type = READ; dcache_req_block_addr = 26'd7;
    #1;
    ok = 1'b0; lat = -1; rdata = '0; nd = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (dcache_req_ready) nd++;
      if (icache_resp_valid) begin ok = 1'b1; lat = cyc - t; rdata = icache_resp_block_data; end
      else begin @(posedge clk); #1; end
    end
    chk("init-mid latency", 128'(lat), 128'(LAT));
    chk("init-mid data", rdata, PAT_A5);
    chk("init-mid no dcache ready", 128'(nd), 128'(0));
    @(posedge clk); #1;
    chk("init-mid idle ready blocked", 128'(dcache_req_ready), 128'(0));
    init = 1'b0;
    #1;
    chk("init released ready", 128'(dcache_req_ready), 128'(1));
    dcache_req_valid = 1'b0;
    #1;

    // MEM_LATENCY=1 instance: response at T+1, ready again at T+2.
    rst_aH = 1'b1;
    @(posedge clk); #1;
    rst_aH = 1'b0;
    icache_req_valid = 1'b1; icache_req_block_addr = 26'd5;
    #1;
    chk("lat1 ready at T", 128'(icache_req_ready_1), 128'(1));
    @(posedge clk); #1;
    chk("lat1 ready at T+1", 128'(icache_req_ready_1), 128'(0));
    chk("lat1 resp_valid at T+1", 128'(icache_resp_valid_1), 128'(1));
    chk("lat1 resp data at T+1", icache_resp_block_data_1, PAT_A5);
    chk("lat1 dcache silent", 128'(dcache_resp_valid_1), 128'(0));
    @(posedge clk); #1;
    chk("lat1 ready at T+2", 128'(icache_req_ready_1), 128'(1));
    chk("lat1 resp_valid at T+2", 128'(icache_resp_valid_1), 128'(0));
    chk("lat1 resp data zero at T+2", icache_resp_block_data_1, 128'h0);
    icache_req_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
